// File: rtl/sr_ccu_isqrt_if.sv
// Operand/result bundle between the schoolRISCV core and the isqrt CCU.
//   master : core side (drives srcA, srcB, oper; observes result, flags, busy, done)
//   slave  : CCU side  (observes operands/oper; drives result, flags, busy, done)
// Handshake: the core issues when oper == OP_START while the unit is idle.
// busy is high on every cycle the unit is computing. done is a single-cycle
// strobe that marks result as valid. The core keeps re-presenting the issuing
// instruction until done, and the unit ignores that re-presentation.
interface sr_ccu_isqrt_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [2:0]       oper;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             sign;
  logic             carry;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output srcA, srcB, oper,
    input  result, zero, sign, carry, overflow, busy, done
  );

  modport slave (
    input  srcA, srcB, oper,
    output result, zero, sign, carry, overflow, busy, done
  );
endinterface

// File: rtl/sr_ccu_isqrt.sv
// Multi-cycle integer square root unit: result = floor(sqrt(srcA)).
// Uses the restoring digit-by-digit method and resolves one root bit per cycle.
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high
//   bus        sr_ccu_isqrt_if.slave (srcA/srcB/oper in; result/flags/busy/done out)
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
module sr_ccu_isqrt #(
  parameter int          WIDTH    = 32,
  parameter int          ITERS    = WIDTH / 2,
  parameter logic [2:0]  OP_START = 3'b111
) (
  input  logic              clk,
  input  logic              rst,
  sr_ccu_isqrt_if.slave     bus,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH+1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   root_q, root_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               start;
  logic [WIDTH+1:0]   r_shift;
  logic [WIDTH+1:0]   trial;
  logic               ge;
  logic [WIDTH-1:0]   root_next;

  // srcB carries no meaning for this operation.
  logic unused_srcb;
  assign unused_srcb = ^bus.srcB;

  assign start = (bus.oper == OP_START);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    rem_d    = rem_q;
    root_d   = root_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    // Bring down the next two radicand bits and test the candidate 4*root+1.
    // rem has two extra bits, so the compare sees the full partial remainder.
    r_shift   = (rem_q << 2) | {{WIDTH{1'b0}}, x_q[WIDTH-1:WIDTH-2]};
    trial     = {root_q, 2'b01};
    ge        = (r_shift >= trial);
    root_next = (root_q << 1) | {{(WIDTH-1){1'b0}}, ge};

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = bus.srcA;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d    = x_q << 2;
        rem_d  = ge ? (r_shift - trial) : r_shift;
        root_d = root_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          result_d = root_next;
          state_d  = DONE;
        end
      end
      // A start seen here is the core re-presenting the issuing instruction
      // to retire it, so the unit returns to IDLE instead of restarting.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done depend on state only, because the core's NOP-injection mux uses busy.
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.result   = result_q;
  assign bus.zero     = ~|result_q;
  assign bus.sign     = 1'b0;
  assign bus.carry    = 1'b0;
  assign bus.overflow = 1'b0;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sr_ccu_isqrt.sv
module tb_sr_ccu_isqrt;
  localparam int         W        = 32;
  localparam int         LAT      = W / 2 + 1;
  localparam logic [2:0] OP_START = 3'b111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_ccu_isqrt_if #(.WIDTH(W)) bus();
  logic [1:0] dbg_state;

  sr_ccu_isqrt #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int unsigned  exp_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Largest r with r*r <= a, found by greedy bit search in 64-bit arithmetic.
  function automatic logic [W-1:0] ref_sqrt(input logic [W-1:0] a);
    longint unsigned r;
    longint unsigned cand;
    r = 0;
    for (int b = W / 2 - 1; b >= 0; b--) begin
      cand = r | (64'd1 << b);
      if (cand * cand <= longint'(a)) r = cand;
    end
    return r[W-1:0];
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [W-1:0] e;
        int unsigned  ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result", bus.result, e);
        check("zero", bus.zero, (e == '0));
        check("flags_sco", {bus.sign, bus.carry, bus.overflow}, 3'b000);
        check("done_cycle", cyc, ec);
        check("busy_in_done", bus.busy, 1'b0);
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one op and walks it through RUN. On return we sit at the negedge of
  // the DONE cycle with oper still presented when hold_start is set.
  task automatic issue(input logic [W-1:0] a, input bit hold_start);
    @(negedge clk);
    bus.oper = OP_START;
    bus.srcA = a;
    bus.srcB = $urandom;
    exp_q.push_back(ref_sqrt(a));
    exp_cyc_q.push_back(cyc + LAT);
    for (int i = 0; i < LAT - 1; i++) begin
      @(negedge clk);
      check("busy_run", bus.busy, 1'b1);
      if (!hold_start) begin
        bus.oper = 3'($urandom_range(0, 7));
        bus.srcA = $urandom;
        bus.srcB = $urandom;
      end
    end
    @(negedge clk);
    // DONE cycle: the monitor checks the result
    if (!hold_start) bus.oper = 3'($urandom_range(0, 6));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.oper = 3'($urandom_range(0, 6));
    end
  endtask

  initial begin
    logic [W-1:0] a;
    bus.srcA = '0;
    bus.srcB = '0;
    bus.oper = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_result", bus.result, '0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_zero", bus.zero, 1'b1);
    check("rst_flags", {bus.sign, bus.carry, bus.overflow}, 3'b000);
    rst = 1'b0;
    idle_cycles(2);
    check("idle_busy", bus.busy, 1'b0);

    // directed values
    issue(32'd0, 1'b0);          idle_cycles(1);
    issue(32'd16, 1'b0);         idle_cycles(1);
    issue(32'd17, 1'b0);         idle_cycles(1);
    issue(32'd15, 1'b0);         idle_cycles(1);
    issue(32'hFFFF_FFFF, 1'b0);  idle_cycles(1);
    issue(32'h4000_0000, 1'b0);  idle_cycles(1);

    // start held through DONE: the retire must not restart the unit
    issue(32'd144, 1'b1);
    @(negedge clk);
    check("hold_idle_busy", bus.busy, 1'b0);
    check("hold_idle_done", bus.done, 1'b0);
    check("hold_result", bus.result, 32'd12);
    bus.oper = 3'b000;
    @(negedge clk);
    check("hold_no_rerun", bus.busy, 1'b0);
    idle_cycles(2);
    check("held_result", bus.result, 32'd12);

    // back-to-back ops; the done-cycle check enforces 18-cycle spacing
    issue(32'd100, 1'b0);
    issue(32'd81, 1'b0);
    idle_cycles(2);

    // reset while the op is in RUN cycle 7
    @(negedge clk);
    bus.oper = OP_START;
    bus.srcA = 32'd1000;
    exp_q.push_back(ref_sqrt(32'd1000));
    exp_cyc_q.push_back(cyc + LAT);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.oper = 3'b000;
    end
    rst = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_done", bus.done, 1'b0);
    check("mid_rst_result", bus.result, '0);
    rst = 1'b0;
    idle_cycles(LAT + 3);
    check("post_rst_busy", bus.busy, 1'b0);

    // randomized operands with varied magnitudes
    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      a = a >> $urandom_range(0, 31);
      issue(a, 1'(n % 5 == 0));
      if (n % 5 == 0) begin
        @(negedge clk);
        bus.oper = 3'b000;
      end
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(LAT + 2);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
